// File: rtl/tx_ctrl.sv
// UART transmit sequencer: latches a byte on start and steps the TX mux select
// through start, 8 data bits (LSB first), optional parity and stop bit(s).
module tx_ctrl #(
  parameter int BAUD_DIV  = 5208,
  parameter int STOP_BITS = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [7:0] d_i,
  input  logic       par_en_i,
  input  logic       par_odd_i,
  output logic [3:0] sel_o,
  output logic [7:0] d_o,
  output logic       p_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [3:0]       sel_q, sel_d;
  logic [7:0]       d_q, d_d;
  logic             p_q, p_d;
  logic             par_en_q, par_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             baud_tick;

  assign baud_tick = (baud_cnt_q == CNT_W'(BAUD_DIV - 1));

  // All state and every output are registered here; a reset aborts any frame.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      sel_q      <= '0;
      d_q        <= '0;
      p_q        <= 1'b0;
      par_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      sel_q      <= sel_d;
      d_q        <= d_d;
      p_q        <= p_d;
      par_en_q   <= par_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = START;
      START:   if (baud_tick) state_d = DATA;
      DATA:    if (baud_tick && bit_idx_q == 3'd7) state_d = par_en_q ? PARITY : STOP;
      PARITY:  if (baud_tick) state_d = STOP;
      STOP:    if (baud_tick && bit_idx_q == 3'(STOP_BITS - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs; bit_idx counts data bits, then stop bits.
  always_comb begin
    baud_cnt_d = '0;
    bit_idx_d  = bit_idx_q;
    sel_d      = sel_q;
    d_d        = d_q;
    p_d        = p_q;
    par_en_d   = par_en_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    if (state_q != IDLE)
      baud_cnt_d = baud_tick ? '0 : baud_cnt_q + CNT_W'(1);
    unique case (state_q)
      IDLE: begin
        sel_d  = 4'd0;
        busy_d = 1'b0;
        if (start_i) begin
          d_d       = d_i;
          p_d       = (^d_i) ^ par_odd_i;
          par_en_d  = par_en_i;
          sel_d     = 4'd1;
          busy_d    = 1'b1;
          bit_idx_d = '0;
        end
      end
      START: begin
        if (baud_tick) begin
          sel_d     = 4'd2;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (bit_idx_q == 3'd7) begin
            sel_d     = par_en_q ? 4'd10 : 4'd0;
            bit_idx_d = '0;
          end else begin
            sel_d     = sel_q + 4'd1;
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (baud_tick) begin
          sel_d     = 4'd0;
          bit_idx_d = '0;
        end
      end
      STOP: begin
        if (baud_tick) begin
          if (bit_idx_q == 3'(STOP_BITS - 1)) begin
            sel_d     = 4'd0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            bit_idx_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      default: begin
        sel_d  = 4'd0;
        busy_d = 1'b0;
      end
    endcase
  end

  assign sel_o  = sel_q;
  assign d_o    = d_q;
  assign p_o    = p_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: doc/tx_ctrl.md
Name: tx_ctrl

Overview:
UART transmit sequencer that drives the select, data and parity inputs of the serial transmit multiplexer. It accepts a byte through a start/busy/done handshake and latches it. It then steps the select code through start, 8 data bits (LSB first), an optional parity bit and stop bit(s), holding each code for exactly one baud period. The block sits between the user/host logic and the TX output mux in the RS-232 path.

Parameters:
BAUD_DIV, 5208, clock cycles per bit (50 MHz / 9600 baud); legal range >= 2
STOP_BITS, 1, number of stop bits; legal values 1 or 2

Ports:
clk_i  input  1  system clock, all logic on rising edge
rst_ni  input  1  asynchronous active-low reset
start_i  input  1  request to send d_i; sampled only in IDLE
d_i  input  8  byte to transmit; latched on the accepted start
par_en_i  input  1  1 = parity bit inserted; latched on the accepted start
par_odd_i  input  1  1 = odd parity, 0 = even parity; latched on the accepted start
sel_o  output  4  mux select: 0 = stop/idle, 1 = start, 2..9 = d[0]..d[7], 10 = parity
d_o  output  8  latched byte, feeds the mux data input
p_o  output  1  latched parity bit, feeds the mux parity input
busy_o  output  1  high while a frame is in progress
done_o  output  1  single-cycle pulse at the end of a frame

Behaviour:
- One clock domain, clk_i. Reset is asynchronous and active-low on rst_ni. Every output is registered.
- Reset values: sel_o=0, d_o=0, p_o=0, busy_o=0, done_o=0. State=IDLE, baud counter=0, bit index=0.
- Reset asserted mid-frame: the frame aborts immediately. The line returns to idle (sel_o=0). No done_o pulse is generated.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: sel_o=0, busy_o=0. If start_i=1 at a clock edge, the block latches d_o<=d_i and computes p_o. It then enters START, sets sel_o=1 and busy_o=1, and clears the baud counter. All of these are visible the cycle after the sampling edge.
- Parity: even, p_o = XOR of d_i (total number of ones, including the parity bit, is even). Odd, p_o = XNOR of d_i.
- Baud counter: counts 0..BAUD_DIV-1. The state or select advances when the counter equals BAUD_DIV-1, so each sel_o value is held exactly BAUD_DIV cycles. Counter width is ceil(log2(BAUD_DIV)).
- START (sel=1) goes to DATA with sel=2.
- DATA (sel=2..9) increments sel_o on each bit boundary. After sel=9:
  - if the latched par_en is 1, go to PARITY (sel=10);
  - otherwise go to STOP (sel=0).
- PARITY (sel=10) goes to STOP (sel=0).
- STOP holds sel=0 for STOP_BITS*BAUD_DIV cycles, then enters IDLE. In that same edge busy_o<=0 and done_o<=1 for exactly one cycle.
- busy_o is high for exactly (9 + P + STOP_BITS)*BAUD_DIV cycles, where P is the latched par_en.
- start_i while busy_o=1 is ignored. It is not queued.
- d_i, par_en_i and par_odd_i changing mid-frame have no effect.
- Back-to-back frames: the done_o cycle is an IDLE cycle. A start_i sampled at its end is accepted, giving zero idle gap beyond the stop bit(s).
- Stop bit(s) and idle share sel=0, so the line stays high between frames.

Test Plan:
1. BAUD_DIV=4, STOP_BITS=1, par_en=1, par_odd=0, d_i=0xA5, 1-cycle start_i pulse -> sel_o sequence 1,2..9,10,0 with each value held 4 cycles; p_o=0; busy_o high 44 cycles; done_o one pulse on the first cycle busy_o=0.
2. d_i=0x00, par_en=1, par_odd=1 -> p_o=1 and sel_o=10 held 4 cycles. Repeat with d_i=0x01, par_odd=0 -> p_o=1.
3. par_en=0, STOP_BITS=2, d_i=0x3C -> sel_o skips 10 (9 then 0); sel=0 held 8 cycles before done_o; busy_o high 44 cycles.
4. start_i held high continuously, d_i changed mid-frame from 0x55 to 0xFF -> first frame sends 0x55 unchanged. A second frame with 0xFF starts in the cycle right after the done_o cycle. No start is accepted while busy_o=1.
5. rst_ni pulled low during DATA (sel=5) -> on the same cycle sel_o=0 and busy_o=0, with no done_o. After release, a new start_i=1 with d_i=0x81 produces a complete correct frame.
6. Bit-timing check at the default BAUD_DIV=5208 -> every sel_o value is stable for exactly 5208 cycles; total frame with parity and 1 stop bit = 57288 cycles.
